// File: rtl/fmul_arbiter_if.sv
// Bus bundle between the fmul_arbiter, its two requesters and the shared multiplier.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface fmul_arbiter_if;
    logic        en;
    logic        req0_valid;
    logic        req1_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req0_ready;
    logic        req1_ready;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp0_c;
    logic [31:0] rsp1_c;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [31:0] mul_c;
    logic        busy;

    modport slave (
        input  en, req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, mul_c,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_c, rsp1_c,
        output mul_a, mul_b, busy
    );

    modport master (
        output en, req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, mul_c,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_c, rsp1_c,
        input  mul_a, mul_b, busy
    );
endinterface

// File: rtl/fmul_arbiter.sv
// Two-requester arbiter in front of a shared pipelined FP32 multiplier.
// A grant issues the winner's operands to the multiplier in the same cycle; an id tag travels
// alongside the product through a MUL_LAT-deep shift register and steers the registered result
// back to the issuing requester. Optional macro FMUL_ARB_RR_EN selects round-robin contention;
// without it requester 0 has fixed priority.
module fmul_arbiter #(
    parameter int unsigned MUL_LAT = 2
) (
    input logic           clk,
    input logic           rst_n,
    fmul_arbiter_if.slave bus
);

    logic               prio1;   // requester 1 wins a contended cycle
    logic               grant0;
    logic               grant1;
    logic               issue;
    logic [MUL_LAT-1:0] tag_valid_q;
    logic [MUL_LAT-1:0] tag_id_q;
    logic               tag_out_valid;
    logic               tag_out_id;
    logic               rsp0_valid_q;
    logic               rsp1_valid_q;
    logic [31:0]        rsp0_c_q;
    logic [31:0]        rsp1_c_q;

`ifdef FMUL_ARB_RR_EN
    logic last_q;   // id granted most recently; resets to 1 so requester 0 wins first

    // Round-robin pointer: moves only on a completed handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (issue) begin
            last_q <= grant1;
        end
    end

    assign prio1 = ~last_q;
`else
    assign prio1 = 1'b0;
`endif

    // Grant decode: combinational, at most one ready, nothing while disabled or in reset
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && bus.en) begin
            if (bus.req0_valid && (!bus.req1_valid || !prio1)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign issue          = grant0 | grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Operand mux to the shared multiplier; zeros when idle
    always_comb begin
        bus.mul_a = 32'h0;
        bus.mul_b = 32'h0;
        if (grant0) begin
            bus.mul_a = bus.req0_a;
            bus.mul_b = bus.req0_b;
        end else if (grant1) begin
            bus.mul_a = bus.req1_a;
            bus.mul_b = bus.req1_b;
        end
    end

    // Tag pipeline: tracks issue validity and owner, aligned with the multiplier latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid_q <= '0;
            tag_id_q    <= '0;
        end else begin
            for (int i = int'(MUL_LAT) - 1; i > 0; i--) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_id_q[i]    <= tag_id_q[i-1];
            end
            tag_valid_q[0] <= issue;
            tag_id_q[0]    <= grant1;
        end
    end

    assign tag_out_valid = tag_valid_q[MUL_LAT-1];
    assign tag_out_id    = tag_id_q[MUL_LAT-1];

    // Response registers: one-cycle strobe to the owner, product held until next response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_c_q     <= 32'h0;
            rsp1_c_q     <= 32'h0;
        end else begin
            rsp0_valid_q <= tag_out_valid && !tag_out_id;
            rsp1_valid_q <= tag_out_valid && tag_out_id;
            if (tag_out_valid && !tag_out_id) begin
                rsp0_c_q <= bus.mul_c;
            end
            if (tag_out_valid && tag_out_id) begin
                rsp1_c_q <= bus.mul_c;
            end
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_c     = rsp0_c_q;
    assign bus.rsp1_c     = rsp1_c_q;
    assign bus.busy       = (|tag_valid_q) | rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter: a behavioural multiplier drives mul_c, and a
// queue-based reference model predicts grants, operands, responses and busy every cycle.
// Honours FMUL_ARB_RR_EN the same way the design does.
module tb_fmul_arbiter;
    localparam int unsigned MUL_LAT = 2;

    logic clk;
    logic rst_n;
    fmul_arbiter_if bus ();

    fmul_arbiter #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Truncating FP32 multiply for normal operands; exact for the small values used below
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] ma;
        logic [47:0] mb;
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'h0 || b[30:0] == 31'h0) return {s, 31'h0};
        ma = {24'h0, 1'b1, a[22:0]};
        mb = {24'h0, 1'b1, b[22:0]};
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            m = p[46:24];
        end else begin
            m = p[45:23];
        end
        return {s, e[7:0], m};
    endfunction

    // Shared multiplier model: MUL_LAT edges from operand capture to product
    logic [31:0] mul_pipe [MUL_LAT];
    initial for (int i = 0; i < int'(MUL_LAT); i++) mul_pipe[i] = 32'h0;
    always @(posedge clk) begin
        mul_pipe[0] <= fmul(bus.mul_a, bus.mul_b);
        for (int i = 1; i < int'(MUL_LAT); i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign bus.mul_c = mul_pipe[MUL_LAT-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] c;
    } ent_t;

    ent_t        pend[$];
    bit          last_id  = 1'b1;
    logic        exp_v0   = 1'b0;
    logic        exp_v1   = 1'b0;
    logic [31:0] exp_c0   = 32'h0;
    logic [31:0] exp_c1   = 32'h0;
    logic        exp_busy = 1'b0;
    bit [1:0]    mg;
    bit [1:0]    cg;

    // Who should be granted right now: {grant1, grant0}
    function automatic bit [1:0] model_grant();
        if (!rst_n || !bus.en) return 2'b00;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef FMUL_ARB_RR_EN
            return last_id ? 2'b01 : 2'b10;
`else
            return 2'b01;
`endif
        end
        if (bus.req0_valid) return 2'b01;
        if (bus.req1_valid) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            last_id  = 1'b1;
            exp_v0   = 1'b0;
            exp_v1   = 1'b0;
            exp_c0   = 32'h0;
            exp_c1   = 32'h0;
            exp_busy = 1'b0;
        end else begin
            mg = model_grant();
            if (mg[0]) begin
                pend.push_back('{cyc + int'(MUL_LAT) + 1, 1'b0, fmul(bus.req0_a, bus.req0_b)});
                last_id = 1'b0;
            end else if (mg[1]) begin
                pend.push_back('{cyc + int'(MUL_LAT) + 1, 1'b1, fmul(bus.req1_a, bus.req1_b)});
                last_id = 1'b1;
            end
            cyc++;
            exp_v0 = 1'b0;
            exp_v1 = 1'b0;
            while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
            if (pend.size() > 0 && pend[0].due == cyc) begin
                if (pend[0].id) begin
                    exp_v1 = 1'b1;
                    exp_c1 = pend[0].c;
                end else begin
                    exp_v0 = 1'b1;
                    exp_c0 = pend[0].c;
                end
            end
            exp_busy = (pend.size() > 0);
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        cg = model_grant();
        check("req0_ready", {31'h0, bus.req0_ready}, {31'h0, cg[0]});
        check("req1_ready", {31'h0, bus.req1_ready}, {31'h0, cg[1]});
        check("mul_a", bus.mul_a, cg[0] ? bus.req0_a : (cg[1] ? bus.req1_a : 32'h0));
        check("mul_b", bus.mul_b, cg[0] ? bus.req0_b : (cg[1] ? bus.req1_b : 32'h0));
        check("rsp0_valid", {31'h0, bus.rsp0_valid}, {31'h0, exp_v0});
        check("rsp1_valid", {31'h0, bus.rsp1_valid}, {31'h0, exp_v1});
        check("rsp0_c", bus.rsp0_c, exp_c0);
        check("rsp1_c", bus.rsp1_c, exp_c1);
        check("busy", {31'h0, bus.busy}, {31'h0, exp_busy});
    end

    // ---------------- Stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                           input bit v1, input logic [31:0] a1, input logic [31:0] b1);
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
    endtask

    task automatic idle();
        set_req(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        e = 8'(110 + $urandom_range(0, 30));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    logic [31:0] kc [8];

    initial begin
        kc = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        rst_n  = 1'b0;
        bus.en = 1'b1;
        set_req(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 32'h3F800000, 32'h3F800000);
        #12;
        // Reset state: no readies even with valid requests
        check("rst_ready0", {31'h0, bus.req0_ready}, 32'h0);
        check("rst_ready1", {31'h0, bus.req1_ready}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_rsp0_c", bus.rsp0_c, 32'h0);
        idle();
        step();
        rst_n = 1'b1;
        step();

        // Single request: 1.5 x 2.0
        set_req(1'b1, 32'h3FC00000, 32'h40000000, 1'b0, 32'h0, 32'h0);
        #1;
        check("single_ready0", {31'h0, bus.req0_ready}, 32'h1);
        step();
        idle();
        step();
        step();
        check("single_rsp0_valid", {31'h0, bus.rsp0_valid}, 32'h1);
        check("single_rsp0_c", bus.rsp0_c, 32'h40400000);
        step();
        check("single_strobe_1cyc", {31'h0, bus.rsp0_valid}, 32'h0);

        // Reset mid-flight discards the operation
        set_req(1'b1, 32'h40000000, 32'h40000000, 1'b0, 32'h0, 32'h0);
        step();
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("flush_rsp0_valid", {31'h0, bus.rsp0_valid}, 32'h0);
        end
        check("flush_busy", {31'h0, bus.busy}, 32'h0);

        // Contention directly after reset: 2x2 from req0, 3x2 from req1
        for (int i = 0; i < 4; i++) begin
`ifdef FMUL_ARB_RR_EN
            set_req(1'b1, 32'h40000000, 32'h40000000, 1'b1, 32'h40400000, 32'h40000000);
            #1;
            check("rr_ready0", {31'h0, bus.req0_ready}, {31'h0, (i % 2) == 0});
            check("rr_ready1", {31'h0, bus.req1_ready}, {31'h0, (i % 2) == 1});
`else
            set_req(i < 3, 32'h40000000, 32'h40000000, 1'b1, 32'h40400000, 32'h40000000);
            #1;
            check("fix_ready0", {31'h0, bus.req0_ready}, {31'h0, i < 3});
            check("fix_ready1", {31'h0, bus.req1_ready}, {31'h0, i == 3});
`endif
            step();
        end
        idle();
`ifdef FMUL_ARB_RR_EN
        check("rr_rsp1_t4", {31'h0, bus.rsp1_valid}, 32'h1);
        check("rr_rsp1_c", bus.rsp1_c, 32'h40C00000);
        step();
        check("rr_rsp0_t5", {31'h0, bus.rsp0_valid}, 32'h1);
        check("rr_rsp0_c", bus.rsp0_c, 32'h40800000);
        step();
        check("rr_rsp1_t6", {31'h0, bus.rsp1_valid}, 32'h1);
`else
        check("fix_rsp0_t4", {31'h0, bus.rsp0_valid}, 32'h1);
        check("fix_rsp0_c", bus.rsp0_c, 32'h40800000);
        step();
        check("fix_rsp0_t5", {31'h0, bus.rsp0_valid}, 32'h1);
        step();
        check("fix_rsp1_t6", {31'h0, bus.rsp1_valid}, 32'h1);
        check("fix_rsp1_c", bus.rsp1_c, 32'h40C00000);
`endif
        step();

        // Gate by en: 3.0 x 4.0 on requester 1
        bus.en = 1'b0;
        set_req(1'b0, 32'h0, 32'h0, 1'b1, 32'h40400000, 32'h40800000);
        #1;
        check("en_low_ready1", {31'h0, bus.req1_ready}, 32'h0);
        step();
        check("en_low_ready1_b", {31'h0, bus.req1_ready}, 32'h0);
        bus.en = 1'b1;
        #1;
        check("en_high_ready1", {31'h0, bus.req1_ready}, 32'h1);
        step();
        idle();
        step();
        step();
        check("en_rsp1_valid", {31'h0, bus.rsp1_valid}, 32'h1);
        check("en_rsp1_c", bus.rsp1_c, 32'h41400000);
        step();

        // Streaming 1.0 x k, k = 1..8
        for (int i = 0; i < 11; i++) begin
            if (i < 8) set_req(1'b1, 32'h3F800000, kc[i], 1'b0, 32'h0, 32'h0);
            else idle();
            #1;
            if (i >= 3) begin
                check("stream_rsp0_valid", {31'h0, bus.rsp0_valid}, 32'h1);
                check("stream_rsp0_c", bus.rsp0_c, kc[i-3]);
            end
            step();
        end
        idle();
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.en = ($urandom_range(0, 9) != 0);
            set_req($urandom_range(0, 2) != 0, rand_fp(), rand_fp(),
                    $urandom_range(0, 2) != 0, rand_fp(), rand_fp());
            step();
        end
        idle();
        bus.en = 1'b1;
        repeat (6) step();
        check("drain_busy", {31'h0, bus.busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 2: edges from operand capture at the multiplier to a valid product on mul_c.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port en, input, 1; high permits new grants.
REQ-005 The block SHALL have ports req0_valid and req1_valid, input, 1 each; requester operand pair present.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32 each; IEEE-754 single operands.
REQ-007 The block SHALL have ports req0_ready and req1_ready, output, 1 each; grant, combinational.
REQ-008 The block SHALL have ports rsp0_valid and rsp1_valid, output, 1 each; one-cycle result strobe, registered.
REQ-009 The block SHALL have ports rsp0_c and rsp1_c, output, 32 each; product, registered.
REQ-010 The block SHALL have ports mul_a and mul_b, output, 32 each; operands driven to the shared pipelined multiplier.
REQ-011 The block SHALL have port mul_c, input, 32; product from the shared multiplier.
REQ-012 The block SHALL have port busy, output, 1; any operation in flight.

Function
REQ-013 The handshake SHALL complete in a cycle where reqN_valid and reqN_ready are both high; at most one ready SHALL be high per cycle.
REQ-014 A grant SHALL require en high; with en low both readies SHALL be low and in-flight operations SHALL still complete.
REQ-015 A single valid requester SHALL be granted in the same cycle; the multiplier accepts one issue every cycle, with no throughput stall.
REQ-016 When both requesters are valid, the winner SHALL follow REQ-030/031.
REQ-017 mul_a/mul_b SHALL carry the granted requester's operands in the grant cycle and 32'h0 when there is no grant.
REQ-018 Each issue SHALL push {valid, id} into a MUL_LAT-deep tag shift register advancing every cycle; no grant pushes valid=0.
REQ-019 When the tag register output is valid, rspID_c SHALL be loaded from mul_c and rspID_valid SHALL be set for exactly one cycle.
REQ-020 Response latency SHALL be MUL_LAT+1 cycles: a handshake in cycle t gives rsp high in cycle t+MUL_LAT+1 (t+3 at default).
REQ-021 rsp_c of the non-addressed requester SHALL hold its previous value.
REQ-022 Responses SHALL return in issue order and SHALL have no backpressure; requesters always accept them.
REQ-023 busy SHALL be high while any tag stage or the response register holds a valid entry.
REQ-024 Back-to-back issues SHALL produce back-to-back responses with no loss or reordering.
REQ-025 Deasserting valid after a handshake SHALL have no effect on the issued operation.

Reset
REQ-026 On rst_n low, all rsp_valid, rsp_c, tag stages and busy SHALL reset to 0 asynchronously.
REQ-027 On rst_n low, the round-robin pointer SHALL reset so that requester 0 wins first.
REQ-028 Operations in flight at reset SHALL be discarded and produce no response after reset release.
REQ-029 Readies SHALL be low while rst_n is low.

Configuration
REQ-030 With FMUL_ARB_RR_EN defined, a contention winner SHALL be the requester not granted most recently, and the pointer SHALL update only on a completed handshake.
REQ-031 Without FMUL_ARB_RR_EN, requester 0 SHALL always win contention; requester 1 is granted only when req0_valid is low.

Verification
REQ-032 Single request: req0 A=3FC00000 (1.5), B=40000000 (2.0) at t -> req0_ready at t; rsp0_valid at t+3 with rsp0_c=40400000.
REQ-033 Contention with RR on: both valid for 4 cycles -> grants 0,1,0,1; rsp0 at t+3, t+5; rsp1 at t+4, t+6; values correct.
REQ-034 Contention with RR off: both valid for 3 cycles -> all grants to 0; req1 granted in the first cycle req0_valid drops.
REQ-035 Gate by en: en low with req1 valid (40400000 x 40800000) -> no ready; raise en -> grant, and 3 cycles later rsp1_c=41400000.
REQ-036 Reset mid-flight: issue at t, pulse rst_n low at t+1 -> no rsp_valid through t+6; busy=0; next contention grants requester 0.
REQ-037 Streaming: req0 valid 8 cycles with 1.0 x k for k=1..8 -> 8 consecutive rsp0 pulses with products 1..8, in order.
